// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, LSB first, one bit per clock,
// with a start/done handshake and a single shared full-subtractor cell.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  import serial_subtractor_pkg::*;

  // Sized for WIDTH+1 values so that WIDTH=1 still gets a 1-bit counter.
  localparam int CW = $clog2(WIDTH + 1);

  state_e           state;
  state_e           state_nxt;
  logic             accept;
  logic             last_bit;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_sh;
  logic [WIDTH-1:0] diff_sh_nxt;
  logic [WIDTH-1:0] diff_q;
  logic             bin;
  logic             borrow_q;
  logic [CW-1:0]    cnt;

  logic             cell_d;
  logic             cell_bout;

  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bin),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Shift-based form keeps the MSB insert legal even when WIDTH=1.
  assign diff_sh_nxt = (diff_sh >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      diff_sh  <= '0;
      diff_q   <= '0;
      bin      <= 1'b0;
      borrow_q <= 1'b0;
      cnt      <= '0;
    end else if (accept) begin
      a_sh    <= bus.a;
      b_sh    <= bus.b;
      diff_sh <= '0;
      bin     <= 1'b0;
      cnt     <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      diff_sh <= diff_sh_nxt;
      bin     <= cell_bout;
      cnt     <= cnt + CW'(1);
      // Result registers load on the final bit so they are valid during DONE.
      if (last_bit) begin
        diff_q   <= diff_sh_nxt;
        borrow_q <= cell_bout;
      end
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, directed
// handshake corner cases and a random sweep against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic one bit wider than the operands.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    r = {1'b0, a} - {1'b0, b};
    return {(a < b), r[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait for its done pulse; operands are scrambled after acceptance.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] d, output logic br,
                       output int edges, output int busy_cycles);
    bit seen;
    seen        = 1'b0;
    edges       = -1;
    busy_cycles = 0;
    d           = '0;
    br          = 1'b0;
    bus.start   = 1'b1;
    bus.a       = a;
    bus.b       = b;
    for (int i = 1; i <= 40 && !seen; i++) begin
      tick();
      if (i == 1) begin
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
      end
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        seen  = 1'b1;
        edges = i;
        d     = bus.diff;
        br    = bus.borrow;
      end
    end
  endtask

  task automatic wait_done(output int edges);
    bit seen;
    seen  = 1'b0;
    edges = -1;
    for (int i = 1; i <= 40 && !seen; i++) begin
      tick();
      if (bus.done) begin
        seen  = 1'b1;
        edges = i;
      end
    end
  endtask

  initial begin
    vec_t         vecs[7];
    logic [W-1:0] d;
    logic         br;
    int           edges;
    int           busy_cycles;
    int           n_done;
    int           n_busy;
    logic [W:0]   exp;

    vecs[0] = '{a: 8'd5,   b: 8'd3,   diff: 8'd2,   borrow: 1'b0};
    vecs[1] = '{a: 8'd3,   b: 8'd5,   diff: 8'd254, borrow: 1'b1};
    vecs[2] = '{a: 8'd0,   b: 8'd255, diff: 8'd1,   borrow: 1'b1};
    vecs[3] = '{a: 8'd0,   b: 8'd0,   diff: 8'd0,   borrow: 1'b0};
    vecs[4] = '{a: 8'd255, b: 8'd255, diff: 8'd0,   borrow: 1'b0};
    vecs[5] = '{a: 8'd128, b: 8'd1,   diff: 8'd127, borrow: 1'b0};
    vecs[6] = '{a: 8'd1,   b: 8'd128, diff: 8'd129, borrow: 1'b1};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    check("reset_busy",   32'(bus.busy),   32'd0);
    check("reset_done",   32'(bus.done),   32'd0);
    check("reset_diff",   32'(bus.diff),   32'd0);
    check("reset_borrow", 32'(bus.borrow), 32'd0);
    rst = 1'b0;
    tick();

    // Vector table: result, latency (9 edges), busy length (8 cycles), done is a pulse.
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, d, br, edges, busy_cycles);
      check($sformatf("vec%0d_latency", i), 32'(edges),       32'd9);
      check($sformatf("vec%0d_busy",    i), 32'(busy_cycles), 32'd8);
      check($sformatf("vec%0d_diff",    i), 32'(d),           32'(vecs[i].diff));
      check($sformatf("vec%0d_borrow",  i), 32'(br),          32'(vecs[i].borrow));
      tick();
      check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
      check($sformatf("vec%0d_diff_hold",  i), 32'(bus.diff), 32'(vecs[i].diff));
    end

    // Start during RUN is ignored and not queued.
    bus.start = 1'b1;
    bus.a     = 8'd7;
    bus.b     = 8'd2;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    check("ign_busy_mid", 32'(bus.busy), 32'd1);
    check("ign_diff_stable", 32'(bus.diff), 32'(vecs[6].diff));
    bus.a     = 8'd9;
    bus.b     = 8'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(edges);
    check("ign_done_seen", 32'(edges >= 0), 32'd1);
    check("ign_diff", 32'(bus.diff), 32'd5);
    n_done = 0;
    n_busy = 0;
    repeat (15) begin
      tick();
      if (bus.done) n_done++;
      if (bus.busy) n_busy++;
    end
    check("ign_extra_done", 32'(n_done), 32'd0);
    check("ign_extra_busy", 32'(n_busy), 32'd0);

    // Back-to-back: start held high through DONE with new operands.
    bus.start = 1'b1;
    bus.a     = 8'd30;
    bus.b     = 8'd10;
    tick();
    bus.a = 8'd20;
    bus.b = 8'd4;
    wait_done(edges);
    check("b2b_first_seen", 32'(edges >= 0), 32'd1);
    check("b2b_first_diff", 32'(bus.diff), 32'd20);
    edges = -1;
    for (int i = 1; i <= 30 && edges < 0; i++) begin
      tick();
      if (i == 1) begin
        bus.start = 1'b0;
        check("b2b_rerun_busy", 32'(bus.busy), 32'd1);
      end
      if (bus.done) edges = i;
    end
    check("b2b_gap",    32'(edges),      32'd9);
    check("b2b_diff",   32'(bus.diff),   32'd16);
    check("b2b_borrow", 32'(bus.borrow), 32'd0);
    tick();

    // Reset in mid-run aborts without a done pulse.
    bus.start = 1'b1;
    bus.a     = 8'd100;
    bus.b     = 8'd37;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("abort_busy",   32'(bus.busy),   32'd0);
    check("abort_done",   32'(bus.done),   32'd0);
    check("abort_diff",   32'(bus.diff),   32'd0);
    check("abort_borrow", 32'(bus.borrow), 32'd0);
    rst    = 1'b0;
    n_done = 0;
    repeat (12) begin
      tick();
      if (bus.done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    do_op(8'd100, 8'd37, d, br, edges, busy_cycles);
    check("abort_fresh_latency", 32'(edges), 32'd9);
    check("abort_fresh_diff",    32'(d),     32'd63);
    check("abort_fresh_borrow",  32'(br),    32'd0);

    // Random sweep against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra  = W'($urandom);
      rb  = W'($urandom);
      exp = model(ra, rb);
      do_op(ra, rb, d, br, edges, busy_cycles);
      check($sformatf("rand%0d_%0d_minus_%0d", i, ra, rb), 32'({br, d}), 32'(exp));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
